// File: rtl/fifo_read_stream.sv
// Read-side adapter after the async FIFO: turns rinc/rempty/rdata into a
// first-word-fall-through valid/ready stream backed by a 2-entry buffer.
module fifo_read_stream #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rempty,
    output logic                 rinc,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [1:0]           level
);

    logic [1:0]           level_q, level_d;
    logic                 inflight_q, inflight_d;
    logic                 m_valid_q, m_valid_d;
    logic [DATAWIDTH-1:0] head_q, head_d;
    logic [DATAWIDTH-1:0] tail_q, tail_d;
    logic                 pop;
    logic [2:0]           credit;

    always_comb begin
        pop    = m_valid_q & m_ready;
        // Occupancy after this cycle's pop, counting the word already on its way.
        credit = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};
        rinc   = !reset && !rempty && (credit < 3'd2);

        inflight_d = rinc;
        level_d    = level_q;
        head_d     = head_q;
        tail_d     = tail_q;

        case ({pop, inflight_q})
            2'b10: begin
                head_d  = tail_q;
                level_d = level_q - 2'd1;
            end
            2'b01: begin
                if (level_q == 2'd0) begin
                    head_d = rdata;
                end else begin
                    tail_d = rdata;
                end
                if (level_q != 2'd2) begin
                    level_d = level_q + 2'd1;
                end
            end
            2'b11: begin
                // Buffer empties this cycle at level 1, so the capture lands in the head.
                if (level_q == 2'd1) begin
                    head_d = rdata;
                end else begin
                    head_d = tail_q;
                    tail_d = rdata;
                end
            end
            default: begin
            end
        endcase

        m_valid_d = (level_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q    <= 2'd0;
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            level_q    <= level_d;
            inflight_q <= inflight_d;
            m_valid_q  <= m_valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign m_data  = head_q;
    assign m_valid = m_valid_q;
    assign level   = level_q;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: table of per-cycle vectors for reset and a single
// word, then a FIFO model with scoreboard for backpressure, streaming, random and reset.
module tb_fifo_read_stream;

    logic       clk;
    logic       reset;
    logic       rempty;
    logic       rinc;
    logic [7:0] rdata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] level;

    fifo_read_stream #(.DATAWIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .rempty  (rempty),
        .rinc    (rinc),
        .rdata   (rdata),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       reset;
        logic       rempty;
        logic       m_ready;
        logic [7:0] rdata;
        logic       exp_rinc;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_level;
        logic       chk_data;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       model_en = 1'b0;
    logic       gap      = 1'b0;
    int         ref_lvl  = 0;
    int         ref_inf  = 0;
    int         n_popped = 0;
    logic       s_rinc, s_mv;
    logic [7:0] s_md;
    logic [1:0] s_lvl;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the FIFO model and scoreboard active.
    task automatic cycle(input logic mr, input logic g);
        int  exp_rinc;
        logic p;
        m_ready = mr;
        gap     = g;
        rempty  = (fifo_q.size() == 0) || gap;
        @(negedge clk);
        s_rinc = rinc;
        s_mv   = m_valid;
        s_md   = m_data;
        s_lvl  = level;
        p      = s_mv && m_ready;
        exp_rinc = (!reset && !rempty && (ref_lvl + ref_inf - (p ? 1 : 0) < 2)) ? 1 : 0;
        chk("rinc", int'(s_rinc), exp_rinc);
        chk("level", int'(s_lvl), ref_lvl);
        chk("m_valid", int'(s_mv), (ref_lvl != 0) ? 1 : 0);
        @(posedge clk);
        #1;
        if (reset) begin
            ref_lvl = 0;
            ref_inf = 0;
        end else begin
            if (p) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("pop_data", int'(s_md), int'(exp_q.pop_front()));
                end
                n_popped++;
            end
            ref_lvl = ref_lvl + ref_inf - (p ? 1 : 0);
            ref_inf = s_rinc ? 1 : 0;
            if (s_rinc) begin
                if (fifo_q.size() == 0) chk("read_of_empty", 1, 0);
                else rdata = fifo_q.pop_front();
            end
        end
        rempty = (fifo_q.size() == 0) || gap;
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    vec_t vecs[12];

    initial begin
        int cnt, first_r, last_r, r_cnt, first_v, last_v, v_cnt, mv_cnt;

        // T1 reset held 3 cycles, then T2 single word 8'hA5 with backpressure.
        vecs[0]  = '{1, 0, 1, 8'h00, 0, 0, 8'h00, 2'd0, 1};
        vecs[1]  = '{1, 0, 1, 8'h00, 0, 0, 8'h00, 2'd0, 1};
        vecs[2]  = '{1, 0, 1, 8'h00, 0, 0, 8'h00, 2'd0, 1};
        vecs[3]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 2'd0, 1};
        vecs[4]  = '{0, 1, 0, 8'hA5, 0, 0, 8'h00, 2'd0, 1};
        vecs[5]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 2'd1, 1};
        vecs[6]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 2'd1, 1};
        vecs[7]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 2'd1, 1};
        vecs[8]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 2'd1, 1};
        vecs[9]  = '{0, 1, 1, 8'h00, 0, 1, 8'hA5, 2'd1, 1};
        vecs[10] = '{0, 1, 1, 8'h00, 0, 0, 8'h00, 2'd0, 0};
        vecs[11] = '{0, 1, 1, 8'h00, 0, 0, 8'h00, 2'd0, 0};

        reset   = 1'b1;
        rempty  = 1'b0;
        m_ready = 1'b1;
        rdata   = 8'h00;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            reset   = vecs[i].reset;
            rempty  = vecs[i].rempty;
            m_ready = vecs[i].m_ready;
            rdata   = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_rinc", i), int'(rinc), int'(vecs[i].exp_rinc));
            chk($sformatf("v%0d_m_valid", i), int'(m_valid), int'(vecs[i].exp_valid));
            chk($sformatf("v%0d_level", i), int'(level), int'(vecs[i].exp_level));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d_m_data", i), int'(m_data), int'(vecs[i].exp_data));
            @(posedge clk);
            #1;
        end

        model_en = 1'b1;
        ref_lvl  = 0;
        ref_inf  = 0;

        // T3 backpressure with 5 words queued.
        for (int i = 1; i <= 5; i++) load(8'(i));
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            if (s_rinc) cnt++;
        end
        chk("t3_rinc_pulses", cnt, 2);
        chk("t3_level_full", int'(s_lvl), 2);
        n_popped = 0;
        for (int i = 0; i < 40 && n_popped < 5; i++) cycle(1'b1, 1'b0);
        chk("t3_drained", n_popped, 5);

        // T4 streaming 16 words with m_ready held high.
        for (int i = 0; i < 16; i++) load(8'(i));
        first_r = -1; last_r = -1; r_cnt = 0;
        first_v = -1; last_v = -1; v_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b0);
            if (s_rinc) begin
                if (first_r < 0) first_r = i;
                last_r = i;
                r_cnt++;
            end
            if (s_mv) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                v_cnt++;
            end
        end
        chk("t4_first_rinc", first_r, 0);
        chk("t4_rinc_count", r_cnt, 16);
        chk("t4_rinc_span", last_r - first_r + 1, 16);
        chk("t4_valid_count", v_cnt, 16);
        chk("t4_valid_span", last_v - first_v + 1, 16);
        chk("t4_latency", first_v - first_r, 2);

        // T5 random backpressure and FIFO gaps over 1000 words.
        for (int i = 0; i < 1000; i++) load(8'($urandom));
        n_popped = 0;
        for (int i = 0; i < 8000 && n_popped < 1000; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
        chk("t5_words_out", n_popped, 1000);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        chk("t5_idle", int'(s_mv), 0);

        // T6 reset with a buffered word and a read in flight; FIFO flushed alongside.
        for (int i = 0; i < 5; i++) load(8'(8'hE0 + i));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t6_pre_level", ref_lvl, 1);
        chk("t6_pre_inflight", ref_inf, 1);
        reset = 1'b1;
        cycle(1'b0, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        cycle(1'b0, 1'b0);
        chk("t6_level", int'(s_lvl), 0);
        chk("t6_m_valid", int'(s_mv), 0);
        chk("t6_rinc", int'(s_rinc), 0);
        chk("t6_m_data", int'(s_md), 0);
        reset  = 1'b0;
        mv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0);
            if (s_mv) mv_cnt++;
        end
        chk("t6_no_stale", mv_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
